// File: rtl/bts_stream_gen.sv
// Binary-to-stochastic stream generator: latches one operand, then emits LEN bits
// of (lfsr_in < operand) under a valid/ready handshake and counts delivered ones.
module bts_stream_gen #(
    parameter int WIDTH = 8,
    parameter int LEN   = 255,
    parameter int CW    = $clog2(LEN + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_value,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] lfsr_in,
    output logic             sbit,
    output logic             sbit_valid,
    output logic             sbit_last,
    input  logic             out_ready,
    output logic [CW-1:0]    ones_count,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam logic [CW-1:0] LAST_IDX = CW'(LEN - 1);
    localparam logic [CW-1:0] ONES_MAX = CW'(LEN);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] value_q, value_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CW-1:0]    ones_q, ones_d;
    logic             sbit_q, sbit_d;
    logic             sbit_valid_q, sbit_valid_d;
    logic             sbit_last_q, sbit_last_d;
    logic             done_q, done_d;

    always_comb begin
        state_d      = state_q;
        value_d      = value_q;
        cnt_d        = cnt_q;
        ones_d       = ones_q;
        sbit_d       = sbit_q;
        sbit_valid_d = sbit_valid_q;
        sbit_last_d  = sbit_last_q;
        done_d       = 1'b0;

        // Count ones as the downstream takes them, not as they are generated.
        if (sbit_valid_q && out_ready && sbit_q && ones_q != ONES_MAX)
            ones_d = ones_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    value_d = in_value;
                    cnt_d   = '0;
                    ones_d  = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!sbit_valid_q || out_ready) begin
                    sbit_d       = (lfsr_in < value_q);
                    sbit_valid_d = 1'b1;
                    sbit_last_d  = (cnt_q == LAST_IDX);
                    cnt_d        = cnt_q + 1'b1;
                    if (cnt_q == LAST_IDX)
                        state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    sbit_valid_d = 1'b0;
                    sbit_last_d  = 1'b0;
                    done_d       = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            value_q      <= '0;
            cnt_q        <= '0;
            ones_q       <= '0;
            sbit_q       <= 1'b0;
            sbit_valid_q <= 1'b0;
            sbit_last_q  <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            value_q      <= value_d;
            cnt_q        <= cnt_d;
            ones_q       <= ones_d;
            sbit_q       <= sbit_d;
            sbit_valid_q <= sbit_valid_d;
            sbit_last_q  <= sbit_last_d;
            done_q       <= done_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign sbit       = sbit_q;
    assign sbit_valid = sbit_valid_q;
    assign sbit_last  = sbit_last_q;
    assign ones_count = ones_q;
    assign done       = done_q;

endmodule

// File: tb/tb_bts_stream_gen.sv
// Directed bench for bts_stream_gen: density table, backpressure, LEN=4,
// back-to-back accepts and asynchronous reset mid-stream.
module tb_bts_stream_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [7:0] in_value, lfsr = 8'd1;
    logic       in_valid, out_ready, in_ready, sbit, sbit_valid, sbit_last, done;
    logic [7:0] ones_count;

    // Maximal-length 8-bit Galois LFSR (x^8+x^6+x^5+x^4+1), free-running.
    always @(posedge clk) lfsr <= lfsr[0] ? ((lfsr >> 1) ^ 8'hB8) : (lfsr >> 1);

    bts_stream_gen #(.WIDTH(8), .LEN(255)) u_dut (
        .clk(clk), .reset(reset), .in_value(in_value), .in_valid(in_valid),
        .in_ready(in_ready), .lfsr_in(lfsr), .sbit(sbit), .sbit_valid(sbit_valid),
        .sbit_last(sbit_last), .out_ready(out_ready), .ones_count(ones_count), .done(done)
    );

    logic [7:0] in_value4, lfsr4;
    logic       in_valid4, out_ready4, in_ready4, sbit4, sbit_valid4, sbit_last4, done4;
    logic [2:0] ones4;

    bts_stream_gen #(.WIDTH(8), .LEN(4)) u_dut4 (
        .clk(clk), .reset(reset), .in_value(in_value4), .in_valid(in_valid4),
        .in_ready(in_ready4), .lfsr_in(lfsr4), .sbit(sbit4), .sbit_valid(sbit_valid4),
        .sbit_last(sbit_last4), .out_ready(out_ready4), .ones_count(ones4), .done(done4)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Runs from just after the accept edge until the last bit is taken. Every load is
    // checked against the LFSR word present at that edge; exp_ones < 0 means "use
    // the number of accepted ones observed".
    task automatic drain_stream(input logic [7:0] v, input bit bp, input int exp_ones);
        int   loaded = 0, nbits = 0, nones = 0, guard = 0;
        bit   fin = 0;
        logic ps, pv, pl, will_load;
        logic [7:0] lw;
        while (!fin && guard < 3000) begin
            guard++;
            out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            ps = sbit; pv = sbit_valid; pl = sbit_last; lw = lfsr;
            will_load = (loaded < 255) && (!pv || out_ready);
            if (pv && out_ready) begin
                nbits++;
                if (ps) nones++;
                if (pl) fin = 1;
            end
            step();
            if (will_load) begin
                chk("bit_value", sbit, lw < v);
                chk("bit_valid", sbit_valid, 1);
                chk("bit_last", sbit_last, loaded == 254);
                loaded++;
            end else if (pv && !out_ready) begin
                chk("stall_sbit", sbit, ps);
                chk("stall_valid", sbit_valid, pv);
                chk("stall_last", sbit_last, pl);
            end
            chk("in_ready", in_ready, fin);
            chk("done", done, fin);
        end
        chk("stream_finished", fin, 1);
        chk("bits_accepted", nbits, 255);
        chk("end_valid", sbit_valid, 0);
        chk("end_last", sbit_last, 0);
        chk("ones_count", ones_count, (exp_ones < 0) ? nones : exp_ones);
    endtask

    task automatic accept(input logic [7:0] v);
        in_value = v;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("accept_in_ready", in_ready, 0);
        chk("accept_valid", sbit_valid, 0);
        chk("accept_ones_clear", ones_count, 0);
    endtask

    typedef struct {
        logic [7:0] value;
        int         exp_ones;
    } vec_t;

    vec_t vecs[4];
    logic exp4[4];
    logic [7:0] words4[4];

    initial begin
        vecs[0] = '{8'd128, 127};
        vecs[1] = '{8'd0,   0};
        vecs[2] = '{8'd255, 254};
        vecs[3] = '{8'd1,   0};
        words4 = '{8'd10, 8'd20, 8'd30, 8'd40};
        exp4   = '{1'b1, 1'b1, 1'b0, 1'b0};

        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_value = 8'd0;
        in_valid4 = 1'b0; out_ready4 = 1'b0; in_value4 = 8'd0; lfsr4 = 8'd0;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_sbit", sbit, 0);
        chk("rst_valid", sbit_valid, 0);
        chk("rst_last", sbit_last, 0);
        chk("rst_ones", ones_count, 0);
        chk("rst_done", done, 0);
        @(negedge clk);
        reset = 1'b1;
        step();

        for (int i = 0; i < 4; i++) begin
            accept(vecs[i].value);
            drain_stream(vecs[i].value, 1'b0, vecs[i].exp_ones);
            step();
            chk("done_one_cycle", done, 0);
        end

        // Random backpressure
        accept(8'd200);
        drain_stream(8'd200, 1'b1, -1);
        out_ready = 1'b1;
        step();
        chk("bp_done_one_cycle", done, 0);

        // LEN=4 with forced LFSR words
        in_value4 = 8'd25; in_valid4 = 1'b1; out_ready4 = 1'b1;
        step();
        in_valid4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            lfsr4 = words4[i];
            step();
            chk("len4_bit", sbit4, exp4[i]);
            chk("len4_last", sbit_last4, i == 3);
        end
        step();
        chk("len4_done", done4, 1);
        chk("len4_ones", ones4, 2);
        chk("len4_valid_off", sbit_valid4, 0);

        // Back-to-back with in_valid held; in_value change mid-stream must be ignored
        in_value = 8'd64; in_valid = 1'b1;
        step();
        in_value = 8'd192;
        drain_stream(8'd64, 1'b0, 63);
        step();
        chk("b2b_accept", in_ready, 0);
        chk("b2b_ones_clear", ones_count, 0);
        chk("b2b_done_off", done, 0);
        in_valid = 1'b0;
        drain_stream(8'd192, 1'b0, 191);
        step();

        // Asynchronous reset at bit 100
        accept(8'd128);
        out_ready = 1'b1;
        repeat (100) step();
        chk("mid_valid", sbit_valid, 1);
        #2 reset = 1'b0;
        #1;
        chk("arst_in_ready", in_ready, 1);
        chk("arst_sbit", sbit, 0);
        chk("arst_valid", sbit_valid, 0);
        chk("arst_last", sbit_last, 0);
        chk("arst_ones", ones_count, 0);
        chk("arst_done", done, 0);
        @(negedge clk);
        reset = 1'b1;
        step();
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_done", done, 0);
        accept(8'd128);
        drain_stream(8'd128, 1'b0, 127);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
